// File: rtl/jogo_pkg.sv
// Shared definitions for the jogo datapath blocks.
//   estado_t  : state encodings, also shown on the 7-seg debug display
//   LedsTodos : all-LEDs-on pattern shown during the echo phase
// Optional feature macro: MOSTRA_ECO_EN adds the StEco state.
package jogo_pkg;

    typedef enum logic [3:0] {
        StOcioso = 4'h0,
        StAcende = 4'h1,
        StApaga  = 4'h2,
`ifdef MOSTRA_ECO_EN
        StEco    = 4'h3,
`endif
        StFim    = 4'hF
    } estado_t;

    localparam logic [3:0] LedsTodos = 4'b1111;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up-counter used as a dwell timer.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   zera         : synchronous clear (has priority over conta)
//   conta        : count enable; wraps from M-1 to 0
//   q            : current count
//   fim          : high while q == M-1
module contador_m #(
    parameter int unsigned M = 4,
    parameter int unsigned W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);

    localparam logic [W-1:0] Ultimo = W'(M - 1);

    logic [W-1:0] q_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else if (zera) begin
            q_q <= '0;
        end else if (conta) begin
            if (q_q == Ultimo) begin
                q_q <= '0;
            end else begin
                q_q <= q_q + 1'b1;
            end
        end
    end

    assign q   = q_q;
    assign fim = (q_q == Ultimo);

endmodule

// File: rtl/mostra_sequencia.sv
// Plays the stored jogada sequence on the LEDs: entries 0..limite are each lit for
// T_ACESO cycles followed by T_APAGADO dark cycles, then pronto pulses for one cycle.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   iniciar       : start request, only looked at while idle
//   limite        : last address to show, latched at start
//   dado_memoria  : jogada read from the ROM at endereco
//   endereco      : ROM read address
//   leds          : LED drive
//   mostrando     : high whenever not idle
//   pronto        : one-cycle end-of-sequence pulse
//   db_estado     : current state encoding for debug
// Optional feature macro: MOSTRA_ECO_EN appends an all-on echo of T_ACESO cycles.
module mostra_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado_memoria,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       mostrando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned TMax = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

    localparam logic [TW-1:0] UltAceso   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] UltApagado = TW'(T_APAGADO - 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    limite_q, limite_d;
    logic          zera_timer, conta_timer;
    logic [TW-1:0] timer_q;
    logic          timer_fim_unused;

    // One timer serves both phases; terminal counts are compared per state, so the
    // counter's own wrap flag is not needed.
    contador_m #(
        .M (TMax),
        .W (TW)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .q     (timer_q),
        .fim   (timer_fim_unused)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= StOcioso;
            endereco_q <= '0;
            limite_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d    = estado_q;
        endereco_d  = endereco_q;
        limite_d    = limite_q;
        zera_timer  = 1'b0;
        conta_timer = 1'b0;
        case (estado_q)
            StOcioso: begin
                if (iniciar) begin
                    limite_d   = limite;
                    endereco_d = '0;
                    zera_timer = 1'b1;
                    estado_d   = StAcende;
                end
            end
            StAcende: begin
                if (timer_q == UltAceso) begin
                    zera_timer = 1'b1;
                    estado_d   = StApaga;
                end else begin
                    conta_timer = 1'b1;
                end
            end
            StApaga: begin
                if (timer_q == UltApagado) begin
                    zera_timer = 1'b1;
                    // Stop on the last address so endereco never wraps past 15.
                    if (endereco_q == limite_q) begin
`ifdef MOSTRA_ECO_EN
                        estado_d = StEco;
`else
                        estado_d = StFim;
`endif
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = StAcende;
                    end
                end else begin
                    conta_timer = 1'b1;
                end
            end
`ifdef MOSTRA_ECO_EN
            StEco: begin
                if (timer_q == UltAceso) begin
                    zera_timer = 1'b1;
                    estado_d   = StFim;
                end else begin
                    conta_timer = 1'b1;
                end
            end
`endif
            StFim: begin
                estado_d = StOcioso;
            end
            default: begin
                estado_d = StOcioso;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        leds      = 4'b0000;
        pronto    = 1'b0;
        mostrando = (estado_q != StOcioso);
        case (estado_q)
            StAcende: leds = dado_memoria;
`ifdef MOSTRA_ECO_EN
            StEco:    leds = LedsTodos;
`endif
            StFim:    pronto = 1'b1;
            default:  ;
        endcase
    end

    assign endereco  = endereco_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_mostra_sequencia.sv
module tb_mostra_sequencia;

    localparam int TA = 4;
    localparam int TP = 2;
`ifdef MOSTRA_ECO_EN
    localparam int ECO = 1;
`else
    localparam int ECO = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    assign dado_memoria = rom[endereco];

    mostra_sequencia #(
        .T_ACESO   (TA),
        .T_APAGADO (TP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .mostrando    (mostrando),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a sequence and follow it cycle by cycle up to the pronto cycle.
    // chg_o: offset at which limite is changed to 1; ini_o: offset of a stray iniciar
    // pulse; hold: keep iniciar high from the pronto cycle on. Ends one cycle after pronto.
    task automatic run_seq(input int lim, input int chg_o, input int ini_o, input bit hold);
        int p;
        int idx;
        int ent;
        int ph;
        logic [3:0] exp_leds;
        logic [3:0] exp_end;
        p = 1 + (lim + 1) * (TA + TP) + ECO * TA;
        limite  = 4'(lim);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int o = 1; o <= p; o++) begin
            idx = o - 1;
            if (o == p) begin
                exp_leds = 4'b0000;
                exp_end  = 4'(lim);
            end else if (idx >= (lim + 1) * (TA + TP)) begin
                exp_leds = 4'b1111;
                exp_end  = 4'(lim);
            end else begin
                ent      = idx / (TA + TP);
                ph       = idx % (TA + TP);
                exp_leds = (ph < TA) ? rom[ent] : 4'b0000;
                exp_end  = 4'(ent);
            end
            check($sformatf("leds[o=%0d]", o), 32'(leds), 32'(exp_leds));
            check($sformatf("endereco[o=%0d]", o), 32'(endereco), 32'(exp_end));
            check($sformatf("pronto[o=%0d]", o), 32'(pronto), 32'(o == p));
            check($sformatf("mostrando[o=%0d]", o), 32'(mostrando), 32'd1);
            iniciar = (o == ini_o) || (hold && o == p);
            if (o == chg_o) limite = 4'd1;
            tick();
        end
    endtask

    task automatic check_idle(input string tag, input int lim);
        check({tag, "_mostrando"}, 32'(mostrando), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_estado"}, 32'(db_estado), 32'h0);
        check({tag, "_leds"}, 32'(leds), 32'h0);
        check({tag, "_endereco"}, 32'(endereco), 32'(lim));
    endtask

    initial begin
        rom = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010,
                4'b0100, 4'b1000, 4'b0011, 4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b1001};
        reset   = 1'b1;
        iniciar = 1'b0;
        limite  = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset", 0);
        tick();
        check_idle("idle", 0);

        // Single entry
        run_seq(0, 0, 0, 1'b0);
        check_idle("lim0_end", 0);

        // Four entries
        run_seq(3, 0, 0, 1'b0);
        check_idle("lim3_end", 3);

        // limite change during first lit phase and stray iniciar mid-run are ignored
        run_seq(3, 2, 9, 1'b0);
        check_idle("ignored_end", 3);

        // Reset in the middle of a run
        limite  = 4'd3;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        repeat (9) tick();
        check("pre_reset_mostrando", 32'(mostrando), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_reset", 0);
        for (int i = 0; i < 30; i++) begin
            check($sformatf("no_pronto[%0d]", i), 32'(pronto), 32'd0);
            tick();
        end
        run_seq(3, 0, 0, 1'b0);
        check_idle("after_reset_end", 3);

        // iniciar held through FIM restarts right after returning to idle
        run_seq(0, 0, 0, 1'b1);
        check("hold_idle_estado", 32'(db_estado), 32'h0);
        check("hold_idle_mostrando", 32'(mostrando), 32'd0);
        run_seq(1, 0, 0, 1'b0);
        check_idle("hold_end", 1);

        // All sixteen entries, no wrap
        run_seq(15, 0, 0, 1'b0);
        check_idle("lim15_end", 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
